actuator_interlock: RTL and testbench
=====================================

// Module: actuator_interlock
// PURPOSE
//  Safety sequencer between processor control outputs and the physical motor/valve drives.
//  Takes raw ctrl requests and enforces mutual exclusion of forward/reverse and fill/release.
//  Enforces a motor dead time after every motor stop and a valve gap after every valve close.
//  Flags conflicting requests. One instance sits between processor and top-level ctrl_* pins.
// PARAMETERS
//  DEAD_CYCLES  16  motor-off cycles after any motor stop (>=1, <=2**CNT_W)
//  VALVE_GAP    4   valve-off cycles after any valve close (>=1, <=2**CNT_W)
//  CNT_W        8   width of both down-counters
// PORTS
//  clk          in   1  system clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  ena          in   1  1: honour requests; 0: all requests treated as 0
//  req_fill     in   1  processor fill-valve request
//  req_release  in   1  processor drain-valve request
//  req_forward  in   1  processor motor-forward request
//  req_reverse  in   1  processor motor-reverse request
//  ctrl_fill    out  1  fill-valve drive (registered)
//  ctrl_release out  1  drain-valve drive (registered)
//  ctrl_forward out  1  motor-forward drive (registered)
//  ctrl_reverse out  1  motor-reverse drive (registered)
//  settling     out  1  1 while motor in M_DEAD or valves in V_GAP
//  fault        out  1  sticky conflict flag
//  fault_clr    in   1  clears fault
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - All ctrl_* = 0, fault = 0, settling = 1.
//   - Motor FSM = M_DEAD with mcnt = DEAD_CYCLES-1.
//   - Valve FSM = V_GAP with vcnt = VALVE_GAP-1.
//   - Result: full dead time/gap is enforced after reset release, including reset mid-operation.
//  Effective requests: r_x = req_x & ena; sampled every rising edge.
//  Motor FSM {M_IDLE, M_FWD, M_REV, M_DEAD}; ctrl_forward=(M_FWD), ctrl_reverse=(M_REV):
//   - M_IDLE: r_fwd&~r_rev -> M_FWD; r_rev&~r_fwd -> M_REV; else stay.
//   - M_FWD: stay while r_fwd&~r_rev; otherwise -> M_DEAD, mcnt<=DEAD_CYCLES-1.
//   - M_REV: symmetric to M_FWD.
//   - M_DEAD: if mcnt!=0, mcnt-- and stay. If mcnt==0, go to M_FWD/M_REV/M_IDLE per current requests, same rule as M_IDLE.
//   - Latency: request to drive = 1 edge from M_IDLE.
//   - Any stop yields exactly DEAD_CYCLES cycles with both motor drives 0. Stop->same direction also pays dead time.
//   - Request pulses that vanish before mcnt==0 are ignored (no memory).
//  Valve FSM {V_IDLE, V_FILL, V_REL, V_GAP}; identical rules with r_fill/r_release, vcnt, VALVE_GAP.
//  Motor and valve FSMs are independent; valves may run while motor runs.
//  Invariant: ctrl_forward&ctrl_reverse==0 and ctrl_fill&ctrl_release==0 in every cycle.
//  Conflict: (r_fwd&r_rev) or (r_fill&r_release) sampled at an edge:
//   - The conflicting pair is treated as no request (running state stops via dead/gap).
//   - fault<=1 at that edge.
//  fault_clr: fault<=0 at next edge unless a conflict is sampled at the same edge (set wins).
//  Counters: CNT_W bits, decrement only in M_DEAD/V_GAP, never wrap below 0.
//  settling = (motor==M_DEAD)|(valve==V_GAP), decoded from registered state.
// TESTING
//  1. Reset release with req_forward=1 held -> ctrl_forward=0 for 16 edges; 1 after 16th edge; settling 1->0 same edge.
//  2. M_FWD, switch to req_reverse at edge N -> ctrl_forward=0 after N; both 0 through N+15; ctrl_reverse=1 after N+16.
//  3. From M_IDLE, req_forward=req_reverse=1 -> both drives stay 0, fault=1 next edge; fault_clr=1 with conflict held -> fault stays 1; conflict removed -> fault clears.
//  4. ctrl_fill=1, swap to req_release at edge N -> ctrl_fill=0 after N; ctrl_release=1 after N+4; motor unaffected.
//  5. M_FWD, ena=0 at edge N -> ctrl_forward=0 after N; ena=1 at N+3 with req_forward=1 -> ctrl_forward=1 after N+16.
//  6. rst_n pulsed low mid-cycle during M_REV -> ctrl_reverse drops immediately (async); after release, dead time of 16 edges before any motor drive.

Source files
------------

// File: rtl/actuator_interlock.sv
`default_nettype none
// ============================================================================
// Module      : actuator_interlock
// Description : Safety sequencer between processor requests and the motor /
//               valve drive pins. Keeps forward/reverse and fill/release
//               mutually exclusive. Holds the motor off for DEAD_CYCLES cycles
//               after every motor stop, and the valves off for VALVE_GAP
//               cycles after every valve close. Sets a sticky fault when a
//               conflicting request pair is sampled.
// Ports       : clk, rst_n (async, active low)
//               ena                    - gate for all requests
//               req_fill/req_release   - valve requests
//               req_forward/req_reverse- motor requests
//               fault_clr              - clears the sticky fault
//               ctrl_fill/ctrl_release/ctrl_forward/ctrl_reverse - drives
//               settling               - motor dead time or valve gap active
//               fault                  - sticky conflict flag
// Revision    : 1.0 - initial release
// ============================================================================
module actuator_interlock #(
  parameter int DEAD_CYCLES = 16,
  parameter int VALVE_GAP   = 4,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic req_fill,
  input  logic req_release,
  input  logic req_forward,
  input  logic req_reverse,
  input  logic fault_clr,
  output logic ctrl_fill,
  output logic ctrl_release,
  output logic ctrl_forward,
  output logic ctrl_reverse,
  output logic settling,
  output logic fault
);

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_FWD  = 2'd1,
    M_REV  = 2'd2,
    M_DEAD = 2'd3
  } motor_e;

  typedef enum logic [1:0] {
    V_IDLE = 2'd0,
    V_FILL = 2'd1,
    V_REL  = 2'd2,
    V_GAP  = 2'd3
  } valve_e;

  localparam logic [CNT_W-1:0] c_dead_init = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_gap_init  = CNT_W'(VALVE_GAP - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  motor_e           m_state_q, m_state_d;
  valve_e           v_state_q, v_state_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             fault_q, fault_d;
  logic             fill_q, release_q, forward_q, reverse_q, settling_q;

  // Effective requests; a conflicting pair collapses to "no request".
  logic r_fill, r_rel, r_fwd, r_rev;
  logic go_fwd, go_rev, go_fill, go_rel;
  logic conflict;

  assign r_fill   = req_fill    & ena;
  assign r_rel    = req_release & ena;
  assign r_fwd    = req_forward & ena;
  assign r_rev    = req_reverse & ena;
  assign go_fwd   = r_fwd  & ~r_rev;
  assign go_rev   = r_rev  & ~r_fwd;
  assign go_fill  = r_fill & ~r_rel;
  assign go_rel   = r_rel  & ~r_fill;
  assign conflict = (r_fwd & r_rev) | (r_fill & r_rel);

  // Motor next-state
  always_comb begin
    m_state_d = m_state_q;
    mcnt_d    = mcnt_q;
    case (m_state_q)
      M_IDLE: begin
        if (go_fwd)      m_state_d = M_FWD;
        else if (go_rev) m_state_d = M_REV;
      end
      M_FWD: begin
        if (!go_fwd) begin
          m_state_d = M_DEAD;
          mcnt_d    = c_dead_init;
        end
      end
      M_REV: begin
        if (!go_rev) begin
          m_state_d = M_DEAD;
          mcnt_d    = c_dead_init;
        end
      end
      M_DEAD: begin
        if (mcnt_q != '0) begin
          mcnt_d = mcnt_q - c_cnt_one;
        end else if (go_fwd) begin
          m_state_d = M_FWD;
        end else if (go_rev) begin
          m_state_d = M_REV;
        end else begin
          m_state_d = M_IDLE;
        end
      end
      default: begin
        m_state_d = M_DEAD;
        mcnt_d    = c_dead_init;
      end
    endcase
  end

  // Valve next-state
  always_comb begin
    v_state_d = v_state_q;
    vcnt_d    = vcnt_q;
    case (v_state_q)
      V_IDLE: begin
        if (go_fill)     v_state_d = V_FILL;
        else if (go_rel) v_state_d = V_REL;
      end
      V_FILL: begin
        if (!go_fill) begin
          v_state_d = V_GAP;
          vcnt_d    = c_gap_init;
        end
      end
      V_REL: begin
        if (!go_rel) begin
          v_state_d = V_GAP;
          vcnt_d    = c_gap_init;
        end
      end
      V_GAP: begin
        if (vcnt_q != '0) begin
          vcnt_d = vcnt_q - c_cnt_one;
        end else if (go_fill) begin
          v_state_d = V_FILL;
        end else if (go_rel) begin
          v_state_d = V_REL;
        end else begin
          v_state_d = V_IDLE;
        end
      end
      default: begin
        v_state_d = V_GAP;
        vcnt_d    = c_gap_init;
      end
    endcase
  end

  // A conflict sampled at the same edge as fault_clr keeps the fault set.
  always_comb begin
    fault_d = fault_q;
    if (conflict)       fault_d = 1'b1;
    else if (fault_clr) fault_d = 1'b0;
  end

  // Drives are dedicated flops loaded from the next-state decode, so each pin
  // is a clean register output that always equals the decode of the state
  // register (no decode glitches on the physical drives).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state_q  <= M_DEAD;
      v_state_q  <= V_GAP;
      mcnt_q     <= c_dead_init;
      vcnt_q     <= c_gap_init;
      fault_q    <= 1'b0;
      fill_q     <= 1'b0;
      release_q  <= 1'b0;
      forward_q  <= 1'b0;
      reverse_q  <= 1'b0;
      settling_q <= 1'b1;
    end else begin
      m_state_q  <= m_state_d;
      v_state_q  <= v_state_d;
      mcnt_q     <= mcnt_d;
      vcnt_q     <= vcnt_d;
      fault_q    <= fault_d;
      fill_q     <= (v_state_d == V_FILL);
      release_q  <= (v_state_d == V_REL);
      forward_q  <= (m_state_d == M_FWD);
      reverse_q  <= (m_state_d == M_REV);
      settling_q <= (m_state_d == M_DEAD) | (v_state_d == V_GAP);
    end
  end

  assign ctrl_fill    = fill_q;
  assign ctrl_release = release_q;
  assign ctrl_forward = forward_q;
  assign ctrl_reverse = reverse_q;
  assign settling     = settling_q;
  assign fault        = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_actuator_interlock.sv
`default_nettype none
// ============================================================================
// Module      : tb_actuator_interlock
// Description : Self-checking bench for actuator_interlock. Directed table of
//               request phases with hand-derived expected drives, hand-written
//               multi-cycle sequences (ena drop, async reset mid-cycle), then
//               randomized requests against a timestamp-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_actuator_interlock;

  localparam int DEAD = 16;
  localparam int GAP  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic ena, req_fill, req_release, req_forward, req_reverse, fault_clr;
  logic ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse, settling, fault;

  always #5 clk = ~clk;

  actuator_interlock #(.DEAD_CYCLES(DEAD), .VALVE_GAP(GAP), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .req_fill     (req_fill),
    .req_release  (req_release),
    .req_forward  (req_forward),
    .req_reverse  (req_reverse),
    .fault_clr    (fault_clr),
    .ctrl_fill    (ctrl_fill),
    .ctrl_release (ctrl_release),
    .ctrl_forward (ctrl_forward),
    .ctrl_reverse (ctrl_reverse),
    .settling     (settling),
    .fault        (fault)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: channel 0 = motor (A=forward, B=reverse),
  // channel 1 = valves (A=fill, B=release). A channel that stops may not
  // start again before edge number ready[ch].
  int ecnt;
  int cur   [2];   // 0 none, 1 A, 2 B
  int ready [2];
  int len   [2];
  bit m_fault;

  function automatic logic [5:0] outs();
    return {ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse, settling, fault};
  endfunction

  function automatic logic [5:0] model_outs();
    logic s;
    s = (cur[0] == 0 && ecnt < ready[0]) || (cur[1] == 0 && ecnt < ready[1]);
    return {cur[1] == 1, cur[1] == 2, cur[0] == 1, cur[0] == 2, s, m_fault};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      cur[c]   = 0;
      ready[c] = ecnt + len[c];
    end
    m_fault = 1'b0;
  endtask

  task automatic model_edge(input bit e, input logic [3:0] rq, input bit clr);
    bit a, b, conf;
    conf = 1'b0;
    ecnt++;
    for (int c = 0; c < 2; c++) begin
      a = e & ((c == 0) ? rq[1] : rq[3]);
      b = e & ((c == 0) ? rq[0] : rq[2]);
      conf |= a & b;
      if (cur[c] != 0) begin
        if ((cur[c] == 1 && !(a && !b)) || (cur[c] == 2 && !(b && !a))) begin
          cur[c]   = 0;
          ready[c] = ecnt + len[c];
        end
      end else if (ecnt >= ready[c]) begin
        cur[c] = (a && !b) ? 1 : (b && !a) ? 2 : 0;
      end
    end
    if (conf)     m_fault = 1'b1;
    else if (clr) m_fault = 1'b0;
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (fill,rel,fwd,rev,settling,fault) at %0t",
                  name, act, exp, $time);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Drive at posedge+1, take one edge, compare with model at posedge+1.
  task automatic step(input bit e, input logic [3:0] rq, input bit clr);
    ena = e;
    {req_fill, req_release, req_forward, req_reverse} = rq;
    fault_clr = clr;
    @(posedge clk);
    model_edge(e, rq, clr);
    #1;
    check("model", outs(), model_outs());
    check_bit("exclusive", (ctrl_forward & ctrl_reverse) | (ctrl_fill & ctrl_release), 1'b0);
  endtask

  typedef struct {
    bit         e;
    logic [3:0] rq;   // {fill, release, forward, reverse}
    bit         clr;
    int         n;
    logic [5:0] exp;  // {fill, release, forward, reverse, settling, fault}
  } vec_t;

  vec_t tbl [16];

  initial begin
    len[0] = DEAD;
    len[1] = GAP;
    ecnt   = 0;
    rst_n  = 1'b0;
    ena = 0; req_fill = 0; req_release = 0; req_forward = 0; req_reverse = 0; fault_clr = 0;

    tbl[0]  = '{1, 4'b0010, 0, 15, 6'b0000_1_0};  // reset dead time with forward held
    tbl[1]  = '{1, 4'b0010, 0,  1, 6'b0010_0_0};  // forward after 16th edge
    tbl[2]  = '{1, 4'b1010, 0,  1, 6'b1010_0_0};  // fill alongside motor
    tbl[3]  = '{1, 4'b0110, 0,  1, 6'b0010_1_0};  // swap to release: fill drops
    tbl[4]  = '{1, 4'b0110, 0,  3, 6'b0010_1_0};
    tbl[5]  = '{1, 4'b0110, 0,  1, 6'b0110_0_0};  // release after N+4
    tbl[6]  = '{1, 4'b0101, 0,  1, 6'b0100_1_0};  // swap to reverse: forward drops
    tbl[7]  = '{1, 4'b0101, 0, 15, 6'b0100_1_0};  // through N+15
    tbl[8]  = '{1, 4'b0101, 0,  1, 6'b0101_0_0};  // reverse after N+16
    tbl[9]  = '{1, 4'b0011, 0,  1, 6'b0000_1_1};  // motor conflict: stop, fault
    tbl[10] = '{1, 4'b0011, 1,  1, 6'b0000_1_1};  // clear loses to conflict
    tbl[11] = '{1, 4'b0000, 1,  1, 6'b0000_1_0};  // clear without conflict
    tbl[12] = '{1, 4'b0000, 0, 20, 6'b0000_0_0};  // everything settles
    tbl[13] = '{0, 4'b1010, 0,  5, 6'b0000_0_0};  // ena=0 masks requests
    tbl[14] = '{1, 4'b1100, 0,  1, 6'b0000_0_1};  // valve conflict from idle
    tbl[15] = '{1, 4'b1000, 1,  1, 6'b1000_0_0};  // clear and fill together

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", outs(), 6'b0000_1_0);
    rst_n = 1'b1;
    model_reset();

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].e, tbl[i].rq, tbl[i].clr);
      check($sformatf("table[%0d]", i), outs(), tbl[i].exp);
    end

    // ena drop while running forward, re-enable at N+3
    step(1, 4'b0010, 0);
    check_bit("ena_fwd_on", ctrl_forward, 1'b1);
    step(0, 4'b0010, 0);
    check_bit("ena_drop_N", ctrl_forward, 1'b0);
    step(0, 4'b0010, 0);
    step(0, 4'b0010, 0);
    for (int k = 3; k <= 15; k++) step(1, 4'b0010, 0);
    check_bit("ena_dead_N15", ctrl_forward, 1'b0);
    step(1, 4'b0010, 0);
    check_bit("ena_fwd_N16", ctrl_forward, 1'b1);

    // Reverse, then async reset mid-cycle
    for (int k = 0; k < 17; k++) step(1, 4'b0001, 0);
    check_bit("rev_running", ctrl_reverse, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", outs(), 6'b0000_1_0);
    #1 rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 15; k++) step(1, 4'b0001, 0);
    check_bit("rst_dead_15", ctrl_reverse, 1'b0);
    step(1, 4'b0001, 0);
    check_bit("rst_rev_16", ctrl_reverse, 1'b1);

    // Randomized phases against the model, with occasional async resets
    for (int p = 0; p < 120; p++) begin
      logic [3:0] rq;
      bit e, clr;
      int hold;
      rq   = 4'($urandom_range(0, 15));
      e    = ($urandom_range(0, 7) != 0);
      clr  = ($urandom_range(0, 3) == 0);
      hold = $urandom_range(1, 20);
      for (int k = 0; k < hold; k++) step(e, rq, clr);
      if ($urandom_range(0, 19) == 0) begin
        #3 rst_n = 1'b0;
        #1;
        check("rand_reset", outs(), 6'b0000_1_0);
        #1 rst_n = 1'b1;
        model_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
